// File: rtl/mips_cpu_sequencer.sv
// mips_cpu_sequencer
//   Multi-cycle instruction sequencer for the MIPS core. Owns the PC and the
//   branch-delay-slot successor (pc_next). It steps each instruction through
//   FETCH/DECODE/EXEC/MEM/WB, stalls on bus waitrequest and on mul/div, and
//   enters HALT when a fetch is attempted at address 0.
// Ports:
//   clk, reset            clock, async active-high reset
//   waitrequest           bus stall; an access completes when low
//   is_load/is_store      decoded memory-access class
//   writes_reg            non-load instruction writes a GPR
//   is_muldiv/muldiv_done mul/div request and completion
//   branch_taken/_target  branch outcome, sampled on EXEC exit
//   pc, pc_plus8          current instruction address and link value
//   state                 FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 HALT=5
//   read, write, addr_sel bus strobes; addr_sel=1 selects data address
//   ir_write              latch instruction word
//   reg_write_en          register-file write enable
//   muldiv_start          one-cycle mul/div start pulse
//   active                core running
module mips_cpu_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        waitrequest,
  input  logic        is_load,
  input  logic        is_store,
  input  logic        writes_reg,
  input  logic        is_muldiv,
  input  logic        muldiv_done,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus8,
  output logic [2:0]  state,
  output logic        read,
  output logic        write,
  output logic        addr_sel,
  output logic        ir_write,
  output logic        reg_write_en,
  output logic        muldiv_start,
  output logic        active
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_pc_next;
  logic        r_md_busy;

  logic w_commit;
  logic w_md_set;
  logic w_read;
  logic w_write;
  logic w_addr_sel;
  logic w_ir_write;
  logic w_reg_write_en;
  logic w_muldiv_start;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_pc      <= RESET_VECTOR;
      r_pc_next <= RESET_VECTOR + 32'd4;
      r_md_busy <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_md_set)
        r_md_busy <= 1'b1;
      else if (w_commit)
        r_md_busy <= 1'b0;
      // Delay slot: the instruction after a branch always runs, so the branch
      // outcome only redirects the successor of the next PC.
      if (w_commit) begin
        r_pc      <= r_pc_next;
        r_pc_next <= branch_taken ? branch_target : r_pc_next + 32'd4;
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_commit       = 1'b0;
    w_md_set       = 1'b0;
    w_read         = 1'b0;
    w_write        = 1'b0;
    w_addr_sel     = 1'b0;
    w_ir_write     = 1'b0;
    w_reg_write_en = 1'b0;
    w_muldiv_start = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (r_pc == '0) begin
          w_state_nxt = S_HALT;
        end else begin
          w_read = 1'b1;
          if (!waitrequest) begin
            w_ir_write  = 1'b1;
            w_state_nxt = S_DECODE;
          end
        end
      end
      S_DECODE: w_state_nxt = S_EXEC;
      S_EXEC: begin
        // Commit on the muldiv_done cycle itself; otherwise the still-asserted
        // is_muldiv would restart the unit once md_busy clears.
        if (r_md_busy) begin
          w_commit = muldiv_done;
        end else if (is_muldiv) begin
          w_muldiv_start = 1'b1;
          w_md_set       = 1'b1;
        end else begin
          w_commit = 1'b1;
        end
        if (w_commit) begin
          if (is_load || is_store)
            w_state_nxt = S_MEM;
          else if (writes_reg)
            w_state_nxt = S_WB;
          else
            w_state_nxt = S_FETCH;
        end
      end
      S_MEM: begin
        w_addr_sel = 1'b1;
        w_read     = is_load;
        w_write    = is_store & ~is_load;
        if (!waitrequest)
          w_state_nxt = is_load ? S_WB : S_FETCH;
      end
      S_WB: begin
        w_reg_write_en = 1'b1;
        w_state_nxt    = S_FETCH;
      end
      S_HALT:  w_state_nxt = S_HALT;
      default: w_state_nxt = S_FETCH;
    endcase
  end

  assign pc           = r_pc;
  assign pc_plus8     = r_pc + 32'd8;
  assign state        = r_state;
  assign read         = w_read & ~reset;
  assign write        = w_write & ~reset;
  assign addr_sel     = w_addr_sel & ~reset;
  assign ir_write     = w_ir_write & ~reset;
  assign reg_write_en = w_reg_write_en & ~reset;
  assign muldiv_start = w_muldiv_start & ~reset;
  assign active       = ~reset & (r_state != S_HALT);

endmodule

// File: tb/tb_mips_cpu_sequencer.sv
module tb_mips_cpu_sequencer;

  logic        clk;
  logic        reset;
  logic        waitrequest;
  logic        is_load;
  logic        is_store;
  logic        writes_reg;
  logic        is_muldiv;
  logic        muldiv_done;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] pc;
  logic [31:0] pc_plus8;
  logic [2:0]  state;
  logic        read;
  logic        write;
  logic        addr_sel;
  logic        ir_write;
  logic        reg_write_en;
  logic        muldiv_start;
  logic        active;

  mips_cpu_sequencer #(.RESET_VECTOR(32'hBFC00000)) dut (
    .clk(clk), .reset(reset), .waitrequest(waitrequest),
    .is_load(is_load), .is_store(is_store), .writes_reg(writes_reg),
    .is_muldiv(is_muldiv), .muldiv_done(muldiv_done),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .pc(pc), .pc_plus8(pc_plus8), .state(state), .read(read), .write(write),
    .addr_sel(addr_sel), .ir_write(ir_write), .reg_write_en(reg_write_en),
    .muldiv_start(muldiv_start), .active(active)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [2:0]  st;
    logic        rd;
    logic        wr;
    logic        as;
    logic        irw;
    logic        rwe;
    logic        mds;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_cyc(input logic [31:0] p, input logic [2:0] s, input logic rd,
                            input logic wr, input logic as, input logic irw,
                            input logic rwe, input logic mds);
    exp_t e;
    e = '{pc: p, st: s, rd: rd, wr: wr, as: as, irw: irw, rwe: rwe, mds: mds};
    sb.push_back(e);
  endtask

  // Monitor: every cycle the core is active is a presented output cycle.
  always @(negedge clk) begin
    exp_t e;
    exp_t a;
    if (!reset && active) begin
      a = '{pc: pc, st: state, rd: read, wr: write, as: addr_sel,
            irw: ir_write, rwe: reg_write_en, mds: muldiv_start};
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_cycle: got %h with no expected entry", a);
      end else begin
        e = sb.pop_front();
        if (a !== e) begin
          n_fail++;
          $display("FAIL cycle_trace: got pc=%h st=%0d rd=%b wr=%b as=%b irw=%b rwe=%b mds=%b expected pc=%h st=%0d rd=%b wr=%b as=%b irw=%b rwe=%b mds=%b",
                   a.pc, a.st, a.rd, a.wr, a.as, a.irw, a.rwe, a.mds,
                   e.pc, e.st, e.rd, e.wr, e.as, e.irw, e.rwe, e.mds);
        end
        n_tests++;
        if (pc_plus8 !== e.pc + 32'd8) begin
          n_fail++;
          $display("FAIL pc_plus8: got %h expected %h", pc_plus8, e.pc + 32'd8);
        end
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    waitrequest = 1'b0; is_load = 1'b0; is_store = 1'b0; writes_reg = 1'b0;
    is_muldiv = 1'b0; muldiv_done = 1'b0; branch_taken = 1'b0; branch_target = '0;
    #1;
    chk("rst_read", {31'd0, read}, 32'd0);
    chk("rst_write", {31'd0, write}, 32'd0);
    chk("rst_active", {31'd0, active}, 32'd0);
    step();
    chk("rst_state", {29'd0, state}, 32'd0);
    chk("rst_pc", pc, 32'hBFC00000);
    chk("rst_pc_plus8", pc_plus8, 32'hBFC00008);
    chk("rst_ir_write", {31'd0, ir_write}, 32'd0);
    step();
    reset = 1'b0;
  endtask

  // kind: 0 plain, 1 ALU writes GPR, 2 load, 3 store, 4 mul/div
  task automatic instr(input logic [31:0] ipc, input logic [31:0] npc, input int kind,
                       input int fw, input int mw, input int md,
                       input logic tk, input logic [31:0] tgt);
    writes_reg = (kind == 1); is_load = (kind == 2); is_store = (kind == 3);
    is_muldiv = (kind == 4); branch_taken = tk; branch_target = tgt; muldiv_done = 1'b0;
    for (int i = 0; i <= fw; i++) begin
      waitrequest = (i < fw);
      expect_cyc(ipc, 3'd0, 1'b1, 1'b0, 1'b0, i == fw, 1'b0, 1'b0);
      step();
    end
    waitrequest = 1'b0;
    expect_cyc(ipc, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    if (kind == 4) begin
      expect_cyc(ipc, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      step();
      for (int i = 0; i < md; i++) begin
        muldiv_done = (i == md - 1);
        expect_cyc(ipc, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
      end
      muldiv_done = 1'b0;
    end else begin
      expect_cyc(ipc, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
    end
    if (kind == 2 || kind == 3) begin
      for (int i = 0; i <= mw; i++) begin
        waitrequest = (i < mw);
        expect_cyc(npc, 3'd3, kind == 2, kind == 3, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
      end
    end
    waitrequest = 1'b0;
    if (kind == 1 || kind == 2) begin
      expect_cyc(npc, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      step();
    end
  endtask

  // FETCH at pc 0 is an active cycle with no read; HALT follows.
  task automatic halt_check();
    writes_reg = 1'b0; is_load = 1'b0; is_store = 1'b0; is_muldiv = 1'b0;
    branch_taken = 1'b0; waitrequest = 1'b0;
    expect_cyc(32'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    for (int i = 0; i < 4; i++) begin
      chk("halt_state", {29'd0, state}, 32'd5);
      chk("halt_active", {31'd0, active}, 32'd0);
      chk("halt_strobes", {27'd0, read, write, ir_write, reg_write_en, muldiv_start}, 32'd0);
      chk("halt_pc", pc, 32'h0);
      step();
    end
  endtask

  initial begin
    do_reset();
    instr(32'hBFC00000, 32'hBFC00004, 1, 0, 0, 0, 1'b0, 32'h0);         // ALU + WB
    instr(32'hBFC00004, 32'hBFC00008, 0, 3, 0, 0, 1'b0, 32'h0);         // fetch stall x3
    instr(32'hBFC00008, 32'hBFC0000C, 2, 0, 2, 0, 1'b0, 32'h0);         // load, 2 waits
    instr(32'hBFC0000C, 32'hBFC00010, 3, 0, 0, 0, 1'b0, 32'h0);         // store
    instr(32'hBFC00010, 32'hBFC00014, 0, 0, 0, 0, 1'b1, 32'hBFC00100);  // taken branch
    instr(32'hBFC00014, 32'hBFC00100, 0, 0, 0, 0, 1'b0, 32'h0);         // delay slot
    instr(32'hBFC00100, 32'hBFC00104, 4, 0, 0, 10, 1'b0, 32'h0);        // DIV
    instr(32'hBFC00104, 32'hBFC00108, 2, 0, 0, 0, 1'b0, 32'h0);         // load, no waits

    // Store stalled in MEM, interrupted by reset.
    writes_reg = 1'b0; is_load = 1'b0; is_store = 1'b1; is_muldiv = 1'b0;
    branch_taken = 1'b0; waitrequest = 1'b0;
    expect_cyc(32'hBFC00108, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    expect_cyc(32'hBFC00108, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    expect_cyc(32'hBFC00108, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    waitrequest = 1'b1;
    for (int i = 0; i < 2; i++) begin
      expect_cyc(32'hBFC0010C, 3'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
    end
    chk("mem_stall_write", {31'd0, write}, 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_mid_write", {31'd0, write}, 32'd0);
    chk("rst_mid_addr_sel", {31'd0, addr_sel}, 32'd0);
    chk("rst_mid_state", {29'd0, state}, 32'd0);
    chk("rst_mid_pc", pc, 32'hBFC00000);
    do_reset();

    // JR to 0: delay slot runs, then halt.
    instr(32'hBFC00000, 32'hBFC00004, 0, 0, 0, 0, 1'b1, 32'h0);
    instr(32'hBFC00004, 32'h00000000, 0, 0, 0, 0, 1'b0, 32'h0);
    halt_check();

    // Wrap: instruction at FFFFFFFC has successor 0, so the core halts.
    do_reset();
    instr(32'hBFC00000, 32'hBFC00004, 0, 0, 0, 0, 1'b1, 32'hFFFFFFFC);
    instr(32'hBFC00004, 32'hFFFFFFFC, 0, 0, 0, 0, 1'b0, 32'h0);
    instr(32'hFFFFFFFC, 32'h00000000, 1, 0, 0, 0, 1'b0, 32'h0);
    halt_check();

    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
